// File: rtl/sha_arith_pkg.sv
// Shared constants and elaboration-time helpers for the SHA-256 modular arithmetic blocks.
package sha_arith_pkg;

  localparam int MODE_TWOS = 0;
  localparam int MODE_ONES = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Extra high bits needed so the raw sum of num_ops W-bit terms plus the +1 count never wraps.
  function automatic int guard_w(input int num_ops);
    return clog2(num_ops + 1);
  endfunction

endpackage

// File: rtl/mod_sum_pipe_csa_3to2.sv
// 3:2 carry-save compressor: a+b+c == sum+carry (mod 2^WIDTH), carry already weighted by 2.
module csa_3to2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/mod_sum_pipe.sv
// Pipelined NUM_OPS-operand modular adder/subtractor (mod 2^W or mod 2^W-1) with valid/ready flow control.
module mod_sum_pipe
  import sha_arith_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_OPS     = 5,
  parameter int PIPE_STAGES = 2,
  parameter int ONES_COMP   = 0
) (
  input  logic                     clock,
  input  logic                     aclr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] operands,
  input  logic [NUM_OPS-1:0]       sub_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     overflow
);

  localparam int G  = guard_w(NUM_OPS);
  localparam int WG = WIDTH + G;
  // Two's-complement mode carries one extra term holding the +1 of every subtracted operand.
  localparam int NT = NUM_OPS + ((ONES_COMP == MODE_TWOS) ? 1 : 0);

  function automatic logic [WG-1:0] popcount_term(input logic [NUM_OPS-1:0] m);
    logic [WG-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_OPS; i++) n = n + WG'(m[i]);
    return n;
  endfunction

  // End-around-carry reduction: the second fold can never carry again; all-ones is negative zero.
  function automatic logic [WIDTH-1:0] fold_ones(input logic [WG-1:0] s);
    logic [WIDTH:0]   t1;
    logic [WIDTH-1:0] t2;
    t1 = {1'b0, s[WIDTH-1:0]} + (WIDTH+1)'(s[WG-1:WIDTH]);
    t2 = t1[WIDTH-1:0] + WIDTH'(t1[WIDTH]);
    return (&t2) ? '0 : t2;
  endfunction

  logic [WG-1:0] term [NT];

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_term
    assign term[i] = {{G{1'b0}}, operands[i*WIDTH +: WIDTH] ^ {WIDTH{sub_mask[i]}}};
  end

  if (NT > NUM_OPS) begin : g_pop
    assign term[NUM_OPS] = popcount_term(sub_mask);
  end

  // Carry-save reduction: each compressor folds one more term into the running sum/carry pair.
  for (genvar k = 1; k < NT; k++) begin : g_red
    logic [WG-1:0] s;
    logic [WG-1:0] c;
    if (k == 1) begin : g_seed
      assign s = term[0];
      assign c = term[1];
    end else begin : g_csa
      csa_3to2 #(.WIDTH(WG)) u_csa (
        .a    (g_red[k-1].s),
        .b    (g_red[k-1].c),
        .c    (term[k]),
        .sum  (s),
        .carry(c)
      );
    end
  end

  logic [WG-1:0] sum_p0;
  logic [WG-1:0] carry_p0;

  assign sum_p0   = g_red[NT-1].s;
  assign carry_p0 = g_red[NT-1].c;

  // Per-stage handshake: a stage loads when empty or when its contents move on this cycle.
  for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_stage
    logic vld_p;
    logic ld;
    logic rdy;
    logic vin;
    if (k == PIPE_STAGES) begin : g_last
      assign rdy = out_ready;
    end else begin : g_mid
      assign rdy = g_stage[k+1].ld;
    end
    if (k == 1) begin : g_first
      assign vin = in_valid;
    end else begin : g_chain
      assign vin = g_stage[k-1].vld_p;
    end
    assign ld = !vld_p || rdy;
    always_ff @(posedge clock) begin
      if (aclr)    vld_p <= 1'b0;
      else if (ld) vld_p <= vin;
    end
  end

  assign in_ready  = g_stage[1].ld;
  assign out_valid = g_stage[PIPE_STAGES].vld_p;

  logic [WG-1:0] sum_fin;
  logic [WG-1:0] carry_fin;

  if (PIPE_STAGES >= 2) begin : g_p1
    logic [WG-1:0] sum_p1;
    logic [WG-1:0] carry_p1;
    // ---- stage 1 boundary: carry-save vectors ----
    always_ff @(posedge clock) begin
      if (in_valid && in_ready) begin
        sum_p1   <= sum_p0;
        carry_p1 <= carry_p0;
      end
    end
    assign sum_fin   = sum_p1;
    assign carry_fin = carry_p1;
  end else begin : g_p1_bypass
    assign sum_fin   = sum_p0;
    assign carry_fin = carry_p0;
  end

  logic [WG-1:0]    total;
  logic [WIDTH-1:0] res_n;
  logic             ovf_n;
  logic             load_out;

  assign total    = sum_fin + carry_fin;
  assign ovf_n    = |total[WG-1:WIDTH];
  assign load_out = g_stage[PIPE_STAGES].ld && g_stage[PIPE_STAGES].vin;

  if (ONES_COMP == MODE_ONES) begin : g_ones
    assign res_n = fold_ones(total);
  end else begin : g_twos
    assign res_n = total[WIDTH-1:0];
  end

  // ---- last stage boundary: result registers ----
  always_ff @(posedge clock) begin
    if (aclr) begin
      result   <= '0;
      overflow <= 1'b0;
    end else if (load_out) begin
      result   <= res_n;
      overflow <= ovf_n;
    end
  end

endmodule

// File: tb/tb_mod_sum_pipe.sv
// Scoreboard bench for mod_sum_pipe: a two's-complement and a ones'-complement instance share stimulus.
module tb_mod_sum_pipe;

  localparam int W = 32;
  localparam int N = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         aclr = 1'b1;
  logic         in_valid = 1'b0;
  logic         dir_ready = 1'b1;
  logic         rnd_ready = 1'b1;
  logic         rnd_mode = 1'b0;
  logic         out_ready;
  logic [N*W-1:0] operands = '0;
  logic [N-1:0] sub_mask = '0;

  logic         in_ready_t, out_valid_t, overflow_t;
  logic [W-1:0] result_t;
  logic         in_ready_o, out_valid_o, overflow_o;
  logic [W-1:0] result_o;

  assign out_ready = rnd_mode ? rnd_ready : dir_ready;

  mod_sum_pipe #(.WIDTH(W), .NUM_OPS(N), .PIPE_STAGES(2), .ONES_COMP(0)) dut_t (
    .clock(clock), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready_t),
    .operands(operands), .sub_mask(sub_mask), .out_valid(out_valid_t),
    .out_ready(out_ready), .result(result_t), .overflow(overflow_t)
  );

  mod_sum_pipe #(.WIDTH(W), .NUM_OPS(N), .PIPE_STAGES(2), .ONES_COMP(1)) dut_o (
    .clock(clock), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready_o),
    .operands(operands), .sub_mask(sub_mask), .out_valid(out_valid_o),
    .out_ready(out_ready), .result(result_o), .overflow(overflow_o)
  );

  typedef struct { logic [W-1:0] res; logic ovf; } exp_t;
  typedef struct {
    logic [N*W-1:0] ops; logic [N-1:0] m;
    logic [W-1:0] r_t; logic o_t; logic [W-1:0] r_o; logic o_o;
  } vec_t;

  exp_t q_t[$];
  exp_t q_o[$];
  int checks = 0;
  int errors = 0;

  logic         hold_t = 1'b0, hold_o = 1'b0;
  logic [W-1:0] held_t = '0, held_o = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [N*W-1:0] pack5(input logic [W-1:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // Reference: plain wide integer sum; mod 2^W-1 taken with the % operator.
  function automatic void model(input logic [N*W-1:0] ops, input logic [N-1:0] m,
                                output logic [W-1:0] r_t, output logic o_t,
                                output logic [W-1:0] r_o, output logic o_o);
    logic [63:0] s_t, s_o, t;
    s_t = '0;
    s_o = '0;
    for (int i = 0; i < N; i++) begin
      t   = {32'h0, m[i] ? ~ops[i*W +: W] : ops[i*W +: W]};
      s_o = s_o + t;
      s_t = s_t + t + 64'(m[i]);
    end
    r_t = s_t[31:0];
    o_t = (s_t[63:32] != 0);
    r_o = 32'(s_o % 64'hFFFF_FFFF);
    o_o = (s_o[63:32] != 0);
  endfunction

  initial forever begin
    @(negedge clock);
    rnd_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the expected result whenever an output transfer is about to happen.
  initial forever begin
    exp_t e;
    @(negedge clock);
    #2;
    if (aclr) begin
      hold_t = 1'b0;
      hold_o = 1'b0;
    end else begin
      if (hold_t) begin
        check("twos_hold_valid", W'(out_valid_t), 32'h1);
        check("twos_hold_result", result_t, held_t);
      end
      if (hold_o) begin
        check("ones_hold_valid", W'(out_valid_o), 32'h1);
        check("ones_hold_result", result_o, held_o);
      end
      if (out_valid_t && out_ready) begin
        if (q_t.size() == 0) begin
          checks++; errors++;
          $display("FAIL twos_unexpected: actual output %h, required none", result_t);
        end else begin
          e = q_t.pop_front();
          check("twos_result", result_t, e.res);
          check("twos_overflow", W'(overflow_t), W'(e.ovf));
        end
      end
      if (out_valid_o && out_ready) begin
        if (q_o.size() == 0) begin
          checks++; errors++;
          $display("FAIL ones_unexpected: actual output %h, required none", result_o);
        end else begin
          e = q_o.pop_front();
          check("ones_result", result_o, e.res);
          check("ones_overflow", W'(overflow_o), W'(e.ovf));
        end
      end
      hold_t = out_valid_t && !out_ready;
      held_t = result_t;
      hold_o = out_valid_o && !out_ready;
      held_o = result_o;
    end
  end

  // Called at a falling edge; returns at the falling edge after the beat is accepted.
  task automatic send(input logic [N*W-1:0] ops, input logic [N-1:0] m,
                      input logic [W-1:0] r_t, input logic o_t,
                      input logic [W-1:0] r_o, input logic o_o, output int waits);
    operands = ops;
    sub_mask = m;
    in_valid = 1'b1;
    waits = 0;
    #1;
    while (!(in_ready_t && in_ready_o) && waits < 200) begin
      @(negedge clock);
      #1;
      waits++;
    end
    if (waits >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: actual in_ready %b/%b after 200 cycles, required 1", in_ready_t, in_ready_o);
      in_valid = 1'b0;
    end else begin
      q_t.push_back('{r_t, o_t});
      q_o.push_back('{r_o, o_o});
    end
    @(negedge clock);
  endtask

  task automatic send_vec(input vec_t v);
    int w;
    send(v.ops, v.m, v.r_t, v.o_t, v.r_o, v.o_o, w);
  endtask

  task automatic send_rand(output int waits);
    logic [N*W-1:0] ops;
    logic [N-1:0]   m;
    logic [W-1:0]   r_t, r_o;
    logic           o_t, o_o;
    for (int i = 0; i < N; i++) begin
      ops[i*W +: W] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
    end
    m = N'($urandom_range(0, 31));
    model(ops, m, r_t, o_t, r_o, o_o);
    send(ops, m, r_t, o_t, r_o, o_o, waits);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((q_t.size() != 0 || q_o.size() != 0) && n < 500) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (q_t.size() != 0 || q_o.size() != 0) begin
      errors++;
      $display("FAIL drain: actual %0d/%0d results pending, required 0", q_t.size(), q_o.size());
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    vec_t vecs [7];
    int   w;
    vecs[0] = '{pack5(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), 5'b00000,
                32'hFFFFFFFB, 1'b1, 32'h00000000, 1'b1};
    vecs[1] = '{pack5(32'd5, 32'd7, 32'd0, 32'd0, 32'd0), 5'b00010,
                32'hFFFFFFFE, 1'b0, 32'hFFFFFFFD, 1'b0};
    vecs[2] = '{pack5(32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'd0), 5'b00000,
                32'h00000000, 1'b1, 32'h00000001, 1'b1};
    vecs[3] = '{pack5(32'h12345678, 32'h12345678, 32'd0, 32'd0, 32'd0), 5'b00010,
                32'h00000000, 1'b1, 32'h00000000, 1'b0};
    vecs[4] = '{pack5(32'd0, 32'd0, 32'd0, 32'd0, 32'd0), 5'b00000,
                32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[5] = '{pack5(32'd0, 32'd0, 32'd0, 32'd0, 32'd0), 5'b11111,
                32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vecs[6] = '{pack5(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0), 5'b00000,
                32'hFFFFFFFF, 1'b1, 32'h00000001, 1'b1};

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_out_valid_t", W'(out_valid_t), 32'h0);
    check("rst_result_t", result_t, 32'h0);
    check("rst_overflow_t", W'(overflow_t), 32'h0);
    check("rst_out_valid_o", W'(out_valid_o), 32'h0);
    check("rst_result_o", result_o, 32'h0);
    @(negedge clock);
    aclr = 1'b0;
    #1;
    check("post_rst_out_valid", W'(out_valid_t | out_valid_o), 32'h0);
    check("post_rst_in_ready", W'(in_ready_t & in_ready_o), 32'h1);
    @(negedge clock);

    // T1 with latency: out_valid must rise exactly two cycles after the accept cycle
    send_vec(vecs[0]);
    in_valid = 1'b0;
    #1;
    check("latency_c1_valid", W'(out_valid_t | out_valid_o), 32'h0);
    @(negedge clock);
    #1;
    check("latency_c2_valid", W'(out_valid_t & out_valid_o), 32'h1);
    @(negedge clock);

    // T2, T3 and boundary vectors back to back
    for (int i = 1; i < 7; i++) send_vec(vecs[i]);
    drain();

    // T4 backpressure: two beats fill the pipe, the third is refused until out_ready returns
    dir_ready = 1'b0;
    for (int k = 0; k < 2; k++) send(pack5(W'(k + 1), 32'h10, 0, 0, 0), '0, W'(k + 17), 1'b0, W'(k + 17), 1'b0, w);
    operands = pack5(32'd3, 32'h10, 0, 0, 0);
    sub_mask = '0;
    in_valid = 1'b1;
    #1;
    check("bp_in_ready_t", W'(in_ready_t), 32'h0);
    check("bp_in_ready_o", W'(in_ready_o), 32'h0);
    repeat (2) @(negedge clock);
    dir_ready = 1'b1;
    for (int k = 2; k < 4; k++) send(pack5(W'(k + 1), 32'h10, 0, 0, 0), '0, W'(k + 17), 1'b0, W'(k + 17), 1'b0, w);
    drain();

    // T5 reset with two beats in flight and a beat offered during reset
    dir_ready = 1'b0;
    send_vec(vecs[0]);
    send_vec(vecs[1]);
    aclr = 1'b1;
    q_t.delete();
    q_o.delete();
    operands = vecs[6].ops;
    sub_mask = vecs[6].m;
    in_valid = 1'b1;
    @(negedge clock);
    aclr = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_mid_valid", W'(out_valid_t | out_valid_o), 32'h0);
    check("rst_mid_result_t", result_t, 32'h0);
    check("rst_mid_result_o", result_o, 32'h0);
    check("rst_mid_overflow", W'(overflow_t | overflow_o), 32'h0);
    dir_ready = 1'b1;
    @(negedge clock);
    #1;
    check("rst_no_stale_valid", W'(out_valid_t | out_valid_o), 32'h0);
    repeat (4) @(negedge clock);
    send_vec(vecs[2]);
    drain();

    // T6 random traffic with random in_valid gaps and random out_ready
    rnd_mode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clock);
      end
      send_rand(w);
    end
    drain();
    rnd_mode = 1'b0;
    dir_ready = 1'b1;

    // Full throughput: every beat must be accepted without waiting
    for (int i = 0; i < 20; i++) begin
      send_rand(w);
      check("throughput_wait", W'(w), 32'h0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
